// File: rtl/iram_loader_pkg.sv
// iram_loader_pkg: shared types and default widths for the instruction-RAM
// loader. The processor top uses IRAM_ADDR_W/IRAM_DATA_W as well.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CSUM state).
package iram_loader_pkg;

  localparam int IRAM_ADDR_W = 9;
  localparam int IRAM_DATA_W = 9;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_t;
`else
  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } loader_state_t;
`endif

  // The loader takes stream words in every state except the two idle ones.
  function automatic logic state_accepts(input loader_state_t s);
    return !(s == ST_DONE || s == ST_ERR);
  endfunction

endpackage

// File: rtl/iram_loader.sv
// iram_loader: streams a length-prefixed program image into instruction RAM
// and holds the processor (cpu_hold) until the image is in place.
// Stream format: N, then N data words written to addresses 0..N-1.
// Optional feature macro: LOADER_CHECKSUM_EN -- a trailing XOR checksum word
// is accepted and compared; a mismatch parks the loader in ERR with err=1.
// The processor top gates its PC/IAR/control-unit clock enables with cpu_hold.
module iram_loader
  import iram_loader_pkg::*;
#(
  parameter int ADDR_W = IRAM_ADDR_W,
  parameter int DATA_W = IRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              iram_we,
  output logic [ADDR_W-1:0] iram_addr,
  output logic [DATA_W-1:0] iram_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_DATA = ST_CSUM;
`else
  localparam loader_state_t AFTER_DATA = ST_DONE;
`endif

  loader_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg;
  logic [ADDR_W-1:0] len_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              ready_reg;
  logic              we_reg;
  logic              done_reg;

  logic              accept;
  logic              last_word;
  logic              restart;
  logic [ADDR_W-1:0] len_word;

  // s_ready is registered, so a handshake can only happen when it is visible.
  assign accept    = s_valid && ready_reg;
  assign len_word  = ADDR_W'(s_data);
  assign last_word = (cnt_reg == len_reg - ADDR_W'(1));
  assign restart   = start && (state_reg == ST_DONE || state_reg == ST_ERR);

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_reg;
  logic              err_reg;
  logic              csum_ok;

  assign csum_ok = (csum_reg == s_data);
  assign err     = err_reg;

  // Running XOR over data words; sticky error until a restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (restart) begin
        csum_reg <= '0;
        err_reg  <= 1'b0;
      end else begin
        if (accept && state_reg == ST_DATA) csum_reg <= csum_reg ^ s_data;
        if (state_reg == ST_CSUM && state_next == ST_ERR) err_reg <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_LEN;
    else        state_reg <= state_next;
  end

  // Next-state logic: LEN -> DATA -> (CSUM) -> DONE/ERR, restart back to LEN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LEN:  if (accept) state_next = (len_word == '0) ? AFTER_DATA : ST_DATA;
      ST_DATA: if (accept && last_word) state_next = AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: if (accept) state_next = csum_ok ? ST_DONE : ST_ERR;
`endif
      ST_DONE: if (start) state_next = ST_LEN;
      ST_ERR:  if (start) state_next = ST_LEN;
      default: state_next = ST_LEN;
    endcase
  end

  // Datapath: length capture, address counter and the one-cycle write stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      len_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      ready_reg <= 1'b0;
      we_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      ready_reg <= state_accepts(state_next);
      we_reg    <= accept && (state_reg == ST_DATA);
      done_reg  <= (state_next == ST_DONE) && (state_reg != ST_DONE);
      if (accept && state_reg == ST_LEN) len_reg <= len_word;
      if (accept && state_reg == ST_DATA) begin
        addr_reg  <= cnt_reg;
        wdata_reg <= s_data;
        cnt_reg   <= cnt_reg + ADDR_W'(1);
      end
      if (restart) cnt_reg <= '0;
    end
  end

  assign s_ready    = ready_reg;
  assign iram_we    = we_reg;
  assign iram_addr  = addr_reg;
  assign iram_wdata = wdata_reg;
  assign done       = done_reg;
  // Keep the CPU held through the cycle that carries the final write.
  assign cpu_hold   = (state_reg != ST_DONE) || we_reg;

endmodule

// File: doc/iram_loader.md
IRAM_LOADER -- requirements
Module: iram_loader

Interface
REQ-001 Parameter ADDR_W, default 9, instruction-memory address width.
REQ-002 Parameter DATA_W, default 9, instruction word width; also the width of the length and checksum words.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to reload; honoured only in DONE or ERR.
REQ-006 s_valid  input  1  host stream word valid.
REQ-007 s_ready  output  1  loader can accept a word this cycle.
REQ-008 s_data  input  DATA_W  host stream word.
REQ-009 iram_we  output  1  instruction-memory write strobe.
REQ-010 iram_addr  output  ADDR_W  instruction-memory write address.
REQ-011 iram_wdata  output  DATA_W  instruction-memory write data.
REQ-012 cpu_hold  output  1  holds the processor PC/IAR/control unit while loading.
REQ-013 done  output  1  one-cycle pulse when a load completes successfully.
REQ-014 err  output  1  sticky checksum-mismatch flag.

Function
REQ-015 A word is accepted only in a cycle with s_valid=1 and s_ready=1; s_valid may assert or deassert freely, and no word is accepted with s_ready=0.
REQ-016 The state machine has states LEN, DATA, CSUM, DONE and ERR.
REQ-017 In LEN, the accepted word is the count N (0..2^ADDR_W-1); N>0 goes to DATA, N=0 goes to CSUM when LOADER_CHECKSUM_EN is defined and to DONE otherwise.
REQ-018 In DATA, the k-th accepted word (k=0..N-1) is written to address k; after word N-1, go to CSUM when LOADER_CHECKSUM_EN is defined and to DONE otherwise.
REQ-019 Write latency is one cycle: a word accepted in cycle t gives iram_we=1, iram_addr=k and iram_wdata=word in cycle t+1; otherwise iram_we=0.
REQ-020 The address counter never wraps: N is at most 2^ADDR_W-1, so the highest address written is 2^ADDR_W-2.
REQ-021 s_ready is 1 in LEN, DATA and CSUM, and 0 in DONE and ERR.
REQ-022 cpu_hold is 1 in every state except DONE, and stays 1 through the cycle of the final iram_we.
REQ-023 done pulses for exactly one cycle, on the first cycle in DONE.
REQ-024 A start pulse in DONE or ERR goes to LEN, clears err, resets the counter and checksum, and sets cpu_hold=1 on the next cycle.
REQ-025 start is ignored in LEN, DATA and CSUM.

Reset
REQ-026 While rst_n=0, outputs are: s_ready=0, iram_we=0, iram_addr=0, iram_wdata=0, cpu_hold=1, done=0, err=0.
REQ-027 While rst_n=0, the state is LEN and the counter and checksum are 0.
REQ-028 After rst_n rises, s_ready=1 from the first clock edge.
REQ-029 Reset mid-load abandons the load with no further writes; any partially written contents stay in IRAM.

Configuration
REQ-030 When LOADER_CHECKSUM_EN is defined: a running XOR of all DATA words is kept, and one extra word is accepted in CSUM.
REQ-031 In CSUM, a match goes to DONE; a mismatch sets err=1 and goes to ERR, where cpu_hold stays 1.
REQ-032 When LOADER_CHECKSUM_EN is undefined: no CSUM state and no checksum register exist, and err is tied to 0.

Structure
REQ-033 A shared package holds the state enumeration and the default widths IRAM_ADDR_W=9 and IRAM_DATA_W=9, which the processor top also uses.
REQ-034 The block has no sub-module; the FSM, counter and checksum live in one module.
REQ-035 The processor top gates the PC, IAR and control-unit clock enables with cpu_hold.

Verification
REQ-036 Reset, then stream 3, 0x1A3, 0x055, 0x0FF (checksum 0x109 when enabled) -> writes addr0=0x1A3, addr1=0x055, addr2=0x0FF, each one cycle after its handshake; then done pulses once, cpu_hold falls and s_ready falls.
REQ-037 Same load with s_valid toggled every other cycle -> identical writes and no duplicates; iram_we appears only after accepted words.
REQ-038 Length 0 -> no iram_we; done after the length word (or after the checksum word 0x000 when enabled).
REQ-039 With LOADER_CHECKSUM_EN, stream 2, 0x001, 0x002, then checksum 0x000 -> err=1, cpu_hold=1, s_ready=0; a following start pulse gives err=0 and state LEN.
REQ-040 Drop rst_n after 2 of 5 data words -> iram_we stops immediately and cpu_hold=1; a fresh load with length 1, word 0x111 writes addr0=0x111.
REQ-041 Full load of 511 words -> final write at addr 0x1FE, no wrap; done asserts once.
